// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   - state_e    : sequencer state encoding
//   - LAST_ITER  : iteration count at which the final step is taken
//   - BOOTH_*    : Booth recoding of {lo[0], q_1}
package multdiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [DEF_CNT_W-1:0] LAST_ITER = DEF_CNT_W'(DEF_WIDTH - 1);

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   is_div    : 1 = restoring-divide step, 0 = radix-2 Booth step
//   hi        : Booth partial product (sign in bit WIDTH) / partial remainder
//   lo        : multiplier being shifted out / quotient being shifted in
//   q_1       : Booth extra bit to the right of lo[0]
//   operand   : sign-extended multiplicand, or zero-extended |divisor|
//   hi_next, lo_next, q_1_next : register value after this step
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] lo,
    input  logic             q_1,
    input  logic [WIDTH:0]   operand,
    output logic [WIDTH:0]   hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             q_1_next
);

    logic signed [WIDTH:0] booth_sum;
    logic [WIDTH:0]        rem_sh;
    logic [WIDTH-1:0]      quo_sh;
    logic [WIDTH+1:0]      trial;

    always_comb begin
        hi_next  = hi;
        lo_next  = lo;
        q_1_next = q_1;

        booth_sum = hi;
        case ({lo[0], q_1})
            BOOTH_ADD: booth_sum = hi + operand;
            BOOTH_SUB: booth_sum = hi - operand;
            default:   booth_sum = hi;
        endcase

        // Remainder can reach just under 2*|B| after the shift, so it needs
        // WIDTH+1 bits; the trial subtraction gets one more bit for its sign.
        rem_sh = {hi[WIDTH-1:0], lo[WIDTH-1]};
        quo_sh = {lo[WIDTH-2:0], 1'b0};
        trial  = {1'b0, rem_sh} - {1'b0, operand};

        if (is_div) begin
            q_1_next = 1'b0;
            if (!trial[WIDTH+1]) begin
                hi_next = trial[WIDTH:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = rem_sh;
                lo_next = quo_sh;
            end
        end else begin
            // Arithmetic right shift of {hi, lo, q_1}.
            hi_next  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            lo_next  = {booth_sum[0], lo[WIDTH-1:1]};
            q_1_next = lo[0];
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply / divide sequencer. One Booth or restoring-divide
// step per clock, WIDTH steps per operation, result presented with a
// one-cycle ready pulse. A new start in any state aborts the current op.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   data_operandA/B   : multiplicand/dividend, multiplier/divisor (signed)
//   ctrl_MULT/ctrl_DIV: single-cycle start pulses (MULT wins if both)
//   data_result       : low product word / quotient, held until next completion
//   data_exception    : overflow or divide-by-zero, held with data_result
//   data_resultRDY    : one-cycle completion pulse
//   busy              : high while iterating
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic             q_1;
    logic [WIDTH:0]   operand;
    logic             div_mode;
    logic             quo_neg;
    logic             div_ovf;
    logic             div_zero;
    logic             zero_wait;

    logic [WIDTH:0]   hi_step;
    logic [WIDTH-1:0] lo_step;
    logic             q_1_step;

    logic             start;
    logic             b_is_zero;
    logic [WIDTH-1:0] result_final;
    logic             exc_final;
    logic [WIDTH:0]   prod_top;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    assign start     = ctrl_MULT | ctrl_DIV;
    assign b_is_zero = (data_operandB == '0);
    assign busy      = (state == MULT) || (state == DIV);

    multdiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div  (div_mode),
        .hi      (hi),
        .lo      (lo),
        .q_1     (q_1),
        .operand (operand),
        .hi_next (hi_step),
        .lo_next (lo_step),
        .q_1_next(q_1_step)
    );

    always_comb begin
        state_next = state;
        if (start) begin
            if (ctrl_MULT)      state_next = MULT;
            else if (b_is_zero) state_next = DONE;
            else                state_next = DIV;
        end else begin
            case (state)
                MULT, DIV: if (count == LAST) state_next = DONE;
                // Divide-by-zero lingers one extra cycle here so its ready
                // pulse still lands a fixed two cycles after the start.
                DONE:      if (!zero_wait) state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Product bits [2*WIDTH-1:WIDTH-1] must all match for the low word to be
    // the exact signed product.
    always_comb begin
        prod_top     = {hi[WIDTH-1:0], lo[WIDTH-1]};
        result_final = lo;
        exc_final    = 1'b0;
        if (div_mode) begin
            if (div_zero) begin
                result_final = '0;
                exc_final    = 1'b1;
            end else begin
                result_final = quo_neg ? negate(lo) : lo;
                exc_final    = div_ovf;
            end
        end else begin
            exc_final = !((&prod_top) || !(|prod_top));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            hi             <= '0;
            lo             <= '0;
            q_1            <= 1'b0;
            operand        <= '0;
            div_mode       <= 1'b0;
            quo_neg        <= 1'b0;
            div_ovf        <= 1'b0;
            div_zero       <= 1'b0;
            zero_wait      <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= state_next;
            data_resultRDY <= 1'b0;
            if (start) begin
                count <= '0;
                hi    <= '0;
                q_1   <= 1'b0;
                if (ctrl_MULT) begin
                    lo        <= data_operandB;
                    operand   <= {data_operandA[WIDTH-1], data_operandA};
                    div_mode  <= 1'b0;
                    quo_neg   <= 1'b0;
                    div_ovf   <= 1'b0;
                    div_zero  <= 1'b0;
                    zero_wait <= 1'b0;
                end else begin
                    lo        <= magnitude(data_operandA);
                    operand   <= {1'b0, magnitude(data_operandB)};
                    div_mode  <= 1'b1;
                    quo_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    div_ovf   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                 (&data_operandB);
                    div_zero  <= b_is_zero;
                    zero_wait <= b_is_zero;
                end
            end else begin
                case (state)
                    MULT, DIV: begin
                        hi    <= hi_step;
                        lo    <= lo_step;
                        q_1   <= q_1_step;
                        count <= count + CNT_W'(1);
                    end
                    DONE: begin
                        if (zero_wait) begin
                            zero_wait <= 1'b0;
                        end else begin
                            data_result    <= result_final;
                            data_exception <= exc_final;
                            data_resultRDY <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
